// File: rtl/jedro_1_rf_sequencer.sv
// Operand-read sequencer in front of a single-port register file.
// Each accepted request reads rs1, then rs2, over the shared port and returns
// both operands on a valid/ready response. Writebacks use the port whenever the
// sequencer is idle or holding a response, and take priority over new requests.
// Optional feature macro: JEDRO_1_RF_BYPASS_EN -- a writeback accepted while a
// response is held refreshes any held operand whose address it matches.
module jedro_1_rf_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_rs1_i,
    input  logic [ADDR_WIDTH-1:0] req_rs2_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [DATA_WIDTH-1:0] op_rs1_data_o,
    output logic [DATA_WIDTH-1:0] op_rs2_data_o,
    input  logic                  wb_valid_i,
    output logic                  wb_ready_o,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_data_o,
    output logic                  rf_we_o,
    input  logic [DATA_WIDTH-1:0] rf_data_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRs1,
        StRs2,
        StCap,
        StOut
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic                  wb_fire;
    logic                  req_fire;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and register-file port drive
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        wb_ready_o  = 1'b0;
        op_valid_o  = 1'b0;
        rf_addr_o   = '0;
        rf_data_o   = '0;
        rf_we_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Readies are gated by reset so they drop the instant reset asserts
                wb_ready_o  = rstn_i;
                req_ready_o = rstn_i & ~wb_valid_i;
            end
            StRs1: begin
                rf_addr_o = rs1_q;
                state_d   = StRs2;
            end
            StRs2: begin
                rf_addr_o = rs2_q;
                state_d   = StCap;
            end
            StCap: begin
                state_d = StOut;
            end
            StOut: begin
                op_valid_o  = 1'b1;
                wb_ready_o  = rstn_i;
                req_ready_o = rstn_i & op_ready_i & ~wb_valid_i;
                if (op_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        wb_fire  = wb_valid_i & wb_ready_o;
        req_fire = req_valid_i & req_ready_o;

        // x0 writes are acknowledged but never reach the register file
        if (wb_fire) begin
            rf_addr_o = wb_addr_i;
            rf_data_o = wb_data_i;
            rf_we_o   = (wb_addr_i != '0);
        end

        if (req_fire) begin
            state_d = StRs1;
        end
    end

    // Operand capture; read data arrives one cycle after its address
    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (state_q == StRs2) begin
            rs1_data_d = (rs1_q == '0) ? '0 : rf_data_i;
        end
        if (state_q == StCap) begin
            rs2_data_d = (rs2_q == '0) ? '0 : rf_data_i;
        end
`ifdef JEDRO_1_RF_BYPASS_EN
        if ((state_q == StOut) && wb_fire && (wb_addr_i != '0)) begin
            if (wb_addr_i == rs1_q) begin
                rs1_data_d = wb_data_i;
            end
            if (wb_addr_i == rs2_q) begin
                rs2_data_d = wb_data_i;
            end
        end
`endif
    end

    // Held request addresses and operand data
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            if (req_fire) begin
                rs1_q <= req_rs1_i;
                rs2_q <= req_rs2_i;
            end
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign op_rs1_data_o = rs1_data_q;
    assign op_rs2_data_o = rs2_data_q;

endmodule

// File: tb/tb_jedro_1_rf_sequencer.sv
// Self-checking bench for jedro_1_rf_sequencer with a register-file model and
// a transaction-level reference: each accepted request expects the register
// contents at acceptance time (x0 reads as zero), one response per request.
module tb_jedro_1_rf_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_rs1_i;
    logic [AW-1:0] req_rs2_i;
    logic          op_valid_o;
    logic          op_ready_i;
    logic [DW-1:0] op_rs1_data_o;
    logic [DW-1:0] op_rs2_data_o;
    logic          wb_valid_i;
    logic          wb_ready_o;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic [AW-1:0] rf_addr_o;
    logic [DW-1:0] rf_data_o;
    logic          rf_we_o;
    logic [DW-1:0] rf_data_i;

    always #5 clk_i = ~clk_i;

    jedro_1_rf_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_rs1_i    (req_rs1_i),
        .req_rs2_i    (req_rs2_i),
        .op_valid_o   (op_valid_o),
        .op_ready_i   (op_ready_i),
        .op_rs1_data_o(op_rs1_data_o),
        .op_rs2_data_o(op_rs2_data_o),
        .wb_valid_i   (wb_valid_i),
        .wb_ready_o   (wb_ready_o),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .rf_we_o      (rf_we_o),
        .rf_data_i    (rf_data_i)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            0:       return 32'hFFFF_FFFF;  // x0 storage returns garbage
            3:       return 32'h0000_0011;
            4:       return 32'h0000_0022;
            5:       return 32'h0000_00AB;
            default: return 32'(i) * 32'h0101_0101;
        endcase
    endfunction

    // Register file: synchronous write, registered read; reloaded during reset
    logic [DW-1:0] mem [32];
    always @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (rf_we_o) begin
            mem[rf_addr_o] <= rf_data_o;
        end
        rf_data_i <= mem[rf_addr_o];
    end

    // Reference state
    logic [DW-1:0] ref_mem [32];
    logic          pend_v, pend_seen;
    logic [AW-1:0] pend_rs1, pend_rs2;
    logic [DW-1:0] exp1, exp2, last_d1, last_d2;
    int            cycle, acc_cyc, last_resp, resp_count;
    logic          b2b_mode;
    logic          req_fire, wb_fire, op_fire;
    int            total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        pend_v    = 1'b0;
        pend_seen = 1'b0;
    endtask

    // One clock: sample mid-low-phase, score, then advance to the next negedge
    task automatic cyc();
        #2;
        req_fire = req_valid_i && req_ready_o;
        wb_fire  = wb_valid_i && wb_ready_o;
        op_fire  = op_valid_o && op_ready_i;
        if (op_valid_o) begin
            chk("op_pending", 32'(pend_v), 32'd1);
            if (pend_v) begin
                if (!pend_seen) begin
                    chk("op_latency", 32'(cycle - acc_cyc), 32'd4);
                    pend_seen = 1'b1;
                end
                chk("op_rs1", op_rs1_data_o, exp1);
                chk("op_rs2", op_rs2_data_o, exp2);
            end
        end
        if (op_fire && pend_v) begin
            if (b2b_mode && last_resp >= 0) chk("b2b_gap", 32'(cycle - last_resp), 32'd4);
            last_resp = cycle;
            resp_count++;
            last_d1   = op_rs1_data_o;
            last_d2   = op_rs2_data_o;
            pend_v    = 1'b0;
            pend_seen = 1'b0;
        end
        if (wb_fire) begin
            chk("wb_we", 32'(rf_we_o), 32'(wb_addr_i != 5'd0));
            chk("wb_addr", 32'(rf_addr_o), 32'(wb_addr_i));
            if (wb_addr_i != 5'd0) begin
                chk("wb_data", rf_data_o, wb_data_i);
                ref_mem[wb_addr_i] = wb_data_i;
`ifdef JEDRO_1_RF_BYPASS_EN
                if (pend_v && (cycle - acc_cyc) >= 4) begin
                    if (wb_addr_i == pend_rs1) exp1 = wb_data_i;
                    if (wb_addr_i == pend_rs2) exp2 = wb_data_i;
                end
`endif
            end
        end else begin
            chk("rf_we_quiet", 32'(rf_we_o), 32'd0);
        end
        if (req_fire) begin
            pend_v    = 1'b1;
            pend_seen = 1'b0;
            pend_rs1  = req_rs1_i;
            pend_rs2  = req_rs2_i;
            exp1      = (req_rs1_i == 5'd0) ? 32'd0 : ref_mem[req_rs1_i];
            exp2      = (req_rs2_i == 5'd0) ? 32'd0 : ref_mem[req_rs2_i];
            acc_cyc   = cycle;
        end
        cycle++;
        @(negedge clk_i);
    endtask

    task automatic send_req(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic got;
        got         = 1'b0;
        req_valid_i = 1'b1;
        req_rs1_i   = a;
        req_rs2_i   = b;
        for (int i = 0; i < 50 && !got; i++) begin
            cyc();
            got = req_fire;
        end
        if (!got) chk("req_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp();
        op_ready_i = 1'b1;
        for (int i = 0; i < 50 && pend_v; i++) cyc();
        if (pend_v) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_valid"}, 32'(op_valid_o), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd0);
        chk({tag, "_wb_ready"}, 32'(wb_ready_o), 32'd0);
        chk({tag, "_rf_we"}, 32'(rf_we_o), 32'd0);
        chk({tag, "_rf_addr"}, 32'(rf_addr_o), 32'd0);
        chk({tag, "_rf_data"}, rf_data_o, 32'd0);
        chk({tag, "_op_rs1"}, op_rs1_data_o, 32'd0);
        chk({tag, "_op_rs2"}, op_rs2_data_o, 32'd0);
    endtask

    initial begin
        int start;
        total = 0; bad = 0; cycle = 0; acc_cyc = 0; last_resp = -1; resp_count = 0;
        b2b_mode = 1'b0; req_fire = 1'b0; wb_fire = 1'b0; op_fire = 1'b0;
        last_d1 = '0; last_d2 = '0; exp1 = '0; exp2 = '0; pend_rs1 = '0; pend_rs2 = '0;
        ref_init();
        // Inputs active during reset so ready/port gating is really exercised
        rstn_i = 1'b0; req_valid_i = 1'b1; req_rs1_i = 5'd3; req_rs2_i = 5'd4;
        op_ready_i = 1'b1; wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h1234_5678;
        #1;
        chk_reset_outputs("rst");
        req_valid_i = 1'b0; wb_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready_o), 32'd1);
        chk("rel_wb_ready", 32'(wb_ready_o), 32'd1);

        // Basic read of preloaded registers
        send_req(5'd3, 5'd4);
        wait_resp();
        chk("t22_rs1", last_d1, 32'h11);
        chk("t22_rs2", last_d2, 32'h22);

        // x0 reads as zero even though the register file returns all ones
        send_req(5'd0, 5'd5);
        wait_resp();
        chk("t23_rs1", last_d1, 32'h0);
        chk("t23_rs2", last_d2, 32'hAB);

        // Writeback wins over a simultaneous request in IDLE
        wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h55;
        req_valid_i = 1'b1; req_rs1_i = 5'd7; req_rs2_i = 5'd4;
        #1;
        chk("t24_we", 32'(rf_we_o), 32'd1);
        chk("t24_req_blocked", 32'(req_ready_o), 32'd0);
        chk("t24_wb_ready", 32'(wb_ready_o), 32'd1);
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("t24_req_ready", 32'(req_ready_o), 32'd1);
        send_req(5'd7, 5'd4);
        wait_resp();
        chk("t24_rs1", last_d1, 32'h55);
        chk("t24_rs2", last_d2, 32'h22);
        // Write to x0 is acknowledged but not performed
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hDEAD_BEEF;
        #1;
        chk("t24_x0_ack", 32'(wb_ready_o), 32'd1);
        chk("t24_x0_we", 32'(rf_we_o), 32'd0);
        cyc();
        wb_valid_i = 1'b0;

        // Stalled response with a matching writeback
        send_req(5'd3, 5'd4);
        op_ready_i = 1'b0;
        for (int i = 0; i < 10 && !pend_seen; i++) cyc();
        chk("t25_in_out", 32'(pend_seen), 32'd1);
        cyc();
        wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h99;
        cyc();
        wb_valid_i = 1'b0;
        cyc();
        cyc();
        #1;
        chk("t25_valid_held", 32'(op_valid_o), 32'd1);
`ifdef JEDRO_1_RF_BYPASS_EN
        chk("t25_rs1", op_rs1_data_o, 32'h99);
`else
        chk("t25_rs1", op_rs1_data_o, 32'h11);
`endif
        chk("t25_rs2", op_rs2_data_o, 32'h22);
        wait_resp();

        // Reset in the middle of a read
        send_req(5'd3, 5'd4);
        cyc();
        req_valid_i = 1'b1; req_rs1_i = 5'd5; req_rs2_i = 5'd3;
        rstn_i = 1'b0;
        #1;
        chk_reset_outputs("mid");
        ref_init();
        req_valid_i = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        #1;
        chk("mid_rel_req_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rel_wb_ready", 32'(wb_ready_o), 32'd1);
        send_req(5'd5, 5'd3);
        wait_resp();
        chk("t26_rs1", last_d1, 32'hAB);
        chk("t26_rs2", last_d2, 32'h11);

        // Back-to-back requests with the consumer always ready
        b2b_mode = 1'b1; last_resp = -1; start = resp_count;
        op_ready_i = 1'b1; req_valid_i = 1'b1;
        req_rs1_i = 5'($urandom_range(0, 31)); req_rs2_i = 5'($urandom_range(0, 31));
        for (int i = 0; i < 100 && (resp_count - start) < 8; i++) begin
            cyc();
            if (req_fire) begin
                req_rs1_i = 5'($urandom_range(0, 31));
                req_rs2_i = 5'($urandom_range(0, 31));
            end
        end
        req_valid_i = 1'b0;
        wait_resp();
        b2b_mode = 1'b0;
        chk("b2b_count", 32'((resp_count - start) >= 8), 32'd1);

        // Randomized traffic: requests, writebacks and consumer stalls mixed
        req_fire = 1'b0; wb_fire = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!req_valid_i || req_fire) begin
                req_valid_i = ($urandom_range(0, 3) != 0);
                req_rs1_i   = 5'($urandom_range(0, 7));
                req_rs2_i   = 5'($urandom_range(0, 7));
            end
            if (!wb_valid_i || wb_fire) begin
                wb_valid_i = ($urandom_range(0, 4) == 0);
                wb_addr_i  = 5'($urandom_range(0, 7));
                wb_data_i  = $urandom;
            end
            op_ready_i = ($urandom_range(0, 2) != 0);
            cyc();
        end
        req_valid_i = 1'b0;
        wb_valid_i  = 1'b0;
        wait_resp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
